// File: rtl/adc_mv_bcd.sv
// ADC code to 4-digit BCD millivolt converter for the scan display.
// Refresh-tick sampling, VREF scaling, then a 14-cycle shift-add-3 conversion.
//
// state | meaning
// IDLE  | waiting for refresh tick, latches data_in on tick
// SCALE | multiply sample by VREF, load binary shift register
// SHIFT | 14 add-3 / shift-left iterations
// DONE  | publish accumulator to BCD4, pulse done
module adc_mv_bcd #(
  parameter int VREF_MV    = 5000,
  parameter int UPDATE_CNT = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  output logic [15:0] BCD4,
  output logic        done
);

  localparam int CW = $clog2(UPDATE_CNT);
  localparam logic [CW-1:0] TC = CW'(UPDATE_CNT - 1);
  localparam logic [21:0] VREF22 = 22'(VREF_MV);

  typedef enum logic [1:0] {IDLE, SCALE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  refresh_cnt;
  logic           tick;
  logic [7:0]     sample;
  logic [13:0]    mv;
  logic [13:0]    bin_sr;
  logic [15:0]    acc;
  logic [15:0]    acc_adj;
  logic [29:0]    shifted;
  logic [3:0]     iter;

  assign tick = (refresh_cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh_cnt <= '0;
    else if (tick) refresh_cnt <= '0;
    else refresh_cnt <= refresh_cnt + CW'(1);
  end

  // Truncating scale: the low 8 product bits are the fractional part.
  always_comb begin
    mv = 14'(({14'd0, sample} * VREF22) >> 8);
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {acc_adj, bin_sr} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SCALE;
      SCALE:   state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      bin_sr <= '0;
      acc    <= '0;
      iter   <= '0;
      BCD4   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (tick) sample <= data_in;
        SCALE: begin
          bin_sr <= mv;
          acc    <= '0;
          iter   <= '0;
        end
        SHIFT: begin
          acc    <= shifted[29:14];
          bin_sr <= shifted[13:0];
          iter   <= iter + 4'd1;
        end
        DONE: begin
          BCD4 <= acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_mv_bcd.sv
// Bench for adc_mv_bcd: two instances (5000 mV and 3300 mV references) checked
// every cycle against an arithmetic model, plus literal expectations.
module tb_adc_mv_bcd;

  localparam int UPD = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_a, data_b;
  logic [15:0] bcd_a, bcd_b;
  logic        done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  adc_mv_bcd #(.VREF_MV(5000), .UPDATE_CNT(UPD)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .BCD4(bcd_a), .done(done_a)
  );

  adc_mv_bcd #(.VREF_MV(3300), .UPDATE_CNT(UPD)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_b), .BCD4(bcd_b), .done(done_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mv_bcd(input int code, input int vref);
    int v;
    v = (code * vref) / 256;
    return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic bad_nibble(input logic [15:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release; tick every UPD edges, result 16 edges later.
  int          cyc = 0;
  int          due = 0;
  logic        pend = 1'b0;
  logic [15:0] pa = '0, pb = '0;
  logic [15:0] exp_bcd_a = '0, exp_bcd_b = '0;
  logic        exp_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      pend      <= 1'b0;
      exp_bcd_a <= '0;
      exp_bcd_b <= '0;
      exp_done  <= 1'b0;
    end else begin
      int n;
      n = cyc + 1;
      cyc <= n;
      exp_done <= 1'b0;
      if (pend && n == due) begin
        exp_bcd_a <= pa;
        exp_bcd_b <= pb;
        exp_done  <= 1'b1;
        pend      <= 1'b0;
      end
      if (n % UPD == 0) begin
        pa   <= mv_bcd(int'(data_a), 5000);
        pb   <= mv_bcd(int'(data_b), 3300);
        due  <= n + 16;
        pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_done_a", {31'd0, done_a}, {31'd0, exp_done});
    check("model_done_b", {31'd0, done_b}, {31'd0, exp_done});
    check("model_bcd_a", {16'd0, bcd_a}, {16'd0, exp_bcd_a});
    check("model_bcd_b", {16'd0, bcd_b}, {16'd0, exp_bcd_b});
    check("nibble_range_a", {31'd0, bad_nibble(bcd_a)}, 32'd0);
    check("nibble_range_b", {31'd0, bad_nibble(bcd_b)}, 32'd0);
  end

  task automatic wait_done(output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done_a) begin
        at_cyc = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: no done within 80 cycles at %0t", $time);
  endtask

  initial begin
    int c;
    rst_n  = 1'b0;
    data_a = 8'd0;
    data_b = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd_a", {16'd0, bcd_a}, 32'h0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    rst_n = 1'b1;

    wait_done(c);
    check("first_done_edge", c, 32'd56);
    wait_done(c);
    check("done_period", c, 32'd96);
    check("zero_code", {16'd0, bcd_a}, 32'h0000);

    data_a = 8'd255; data_b = 8'd200;
    wait_done(c);
    check("a_255", {16'd0, bcd_a}, 32'h4980);
    check("b_200", {16'd0, bcd_b}, 32'h2578);

    data_a = 8'd128; data_b = 8'd255;
    wait_done(c);
    check("a_128", {16'd0, bcd_a}, 32'h2500);
    check("b_255", {16'd0, bcd_b}, 32'h3287);

    data_a = 8'd1;
    wait_done(c);
    check("a_1", {16'd0, bcd_a}, 32'h0019);

    data_a = 8'd128;
    wait_done(c);
    check("a_128_again", {16'd0, bcd_a}, 32'h2500);

    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (cyc % UPD == 3) break;
    end
    data_a = 8'd255;
    wait_done(c);
    check("mid_change_hold", {16'd0, bcd_a}, 32'h2500);
    wait_done(c);
    check("mid_change_next", {16'd0, bcd_a}, 32'h4980);

    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (cyc % UPD == 8) break;
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_bcd", {16'd0, bcd_a}, 32'h0);
    check("async_rst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(c);
    check("post_rst_first_done", c, 32'd56);
    check("post_rst_bcd", {16'd0, bcd_a}, 32'h4980);

    for (int code = 0; code < 256; code++) begin
      data_a = 8'(code);
      data_b = 8'(255 - code);
      wait_done(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
